// File: rtl/spi_master_param_if.sv
// SPI master signal bundle: frame request/config inputs, serial pins, status.
// master: the SPI master block; slave: whoever drives requests and the MISO pin.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 4,
  parameter int DIV_W  = 8
);
  logic              start_i;
  logic [DATA_W-1:0] tx_data_i;
  logic [CS_W-1:0]   cs_sel_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              lsb_first_i;
  logic [DIV_W-1:0]  div_i;
  logic              lpbk_i;
  logic              miso_i;
  logic              sclk_o;
  logic              mosi_o;
  logic [CS_W-1:0]   cs_n_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] rx_data_o;

  modport master (
    input  start_i, tx_data_i, cs_sel_i, cpol_i, cpha_i,
    input  lsb_first_i, div_i, lpbk_i, miso_i,
    output sclk_o, mosi_o, cs_n_o, busy_o, done_o, rx_data_o
  );

  modport slave (
    output start_i, tx_data_i, cs_sel_i, cpol_i, cpha_i,
    output lsb_first_i, div_i, lpbk_i, miso_i,
    input  sclk_o, mosi_o, cs_n_o, busy_o, done_o, rx_data_o
  );
endinterface

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one DATA_W-bit frame per start, modes 0-3, MSB/LSB first.
// Ports: PCLK, PRESETn (async, active low), bus (spi_master_param_if.master):
//   start_i/tx_data_i/cs_sel_i/cpol_i/cpha_i/lsb_first_i/div_i/lpbk_i/miso_i in,
//   sclk_o/mosi_o/cs_n_o/busy_o/done_o/rx_data_o out.
// SPI_LOOPBACK_EN: when defined, a frame started with lpbk_i=1 samples mosi_o.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 4,
  parameter int DIV_W  = 8
) (
  input logic                PCLK,
  input logic                PRESETn,
  spi_master_param_if.master bus
);
  localparam int EW = $clog2(2 * DATA_W);
  localparam int IW = EW - 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);
  localparam logic [IW-1:0] TOP_BIT   = IW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    CONFIGURE    = 2'b01,
    TRANSFER     = 2'b11,
    TRANSFER_END = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [CS_W-1:0]   cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic cpha_q, cpha_d;
  logic lsb_q, lsb_d;
  logic lpbk_q, lpbk_d;
  logic done_q, done_d;

  logic          tick;
  logic          lead;
  logic          last;
  logic          rx_in;
  logic [IW-1:0] bit_idx;

  // Bit position within the word for the b-th bit on the wire.
  function automatic logic [IW-1:0] pos(
    input logic          lsb,
    input logic [IW-1:0] b
  );
    return lsb ? b : TOP_BIT - b;
  endfunction

`ifdef SPI_LOOPBACK_EN
  assign rx_in = lpbk_q ? mosi_q : bus.miso_i;
`else
  logic lpbk_unused;
  assign lpbk_unused = lpbk_q;
  assign rx_in       = bus.miso_i;
`endif

  assign tick    = (cnt_q == div_q);
  // Even edge count = next edge is a leading edge.
  assign lead    = ~edge_q[0];
  assign last    = (edge_q == LAST_EDGE);
  assign bit_idx = edge_q[EW-1:1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      cs_n_q  <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      lpbk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      lpbk_q  <= lpbk_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    lpbk_d  = lpbk_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = CONFIGURE;
          tx_d    = bus.tx_data_i;
          div_d   = bus.div_i;
          cpha_d  = bus.cpha_i;
          lsb_d   = bus.lsb_first_i;
          lpbk_d  = bus.lpbk_i;
          cs_n_d  = ~bus.cs_sel_i;
          sclk_d  = bus.cpol_i;
          mosi_d  = bus.lsb_first_i ? bus.tx_data_i[0]
                                    : bus.tx_data_i[DATA_W-1];
          cnt_d   = '0;
          edge_d  = '0;
          rx_sh_d = '0;
        end
      end
      CONFIGURE: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d   = '0;
          state_d = TRANSFER;
        end
      end
      TRANSFER: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          // Sample on leading edges for CPHA=0, trailing for CPHA=1.
          if (lead ^ cpha_q) begin
            rx_sh_d[pos(lsb_q, bit_idx)] = rx_in;
          end else if (cpha_q) begin
            mosi_d = tx_q[pos(lsb_q, bit_idx)];
          end else if (!last) begin
            mosi_d = tx_q[pos(lsb_q, bit_idx + 1'b1)];
          end
          if (last) begin
            state_d = TRANSFER_END;
          end
        end
      end
      TRANSFER_END: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          cs_n_d  = '1;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sclk_o    = sclk_q;
  assign bus.mosi_o    = mosi_q;
  assign bus.cs_n_o    = cs_n_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = done_q;
  assign bus.rx_data_o = rx_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Randomised bench for spi_master_param with an SPI-slave reference model.
// Checks latency, edge count, CS, wire bit order, received data, reset.
module tb_spi_master_param;
  localparam int DATA_W = 8;
  localparam int CS_W   = 4;
  localparam int DIV_W  = 8;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  spi_master_param_if #(
    .DATA_W(DATA_W), .CS_W(CS_W), .DIV_W(DIV_W)
  ) bus ();

  spi_master_param #(
    .DATA_W(DATA_W), .CS_W(CS_W), .DIV_W(DIV_W)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int                r_lat;
  int                r_cs_bad;
  logic              r_sclk0;
  logic [DATA_W-1:0] r_rcv;
  logic [DATA_W-1:0] r_arr;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: slave shifts out sdata; 1: MISO wired to MOSI;
  // 2: MISO held at sdata[0]; 3: loopback request, MISO held 0.
  // Called at a negedge; returns at the negedge after done's cycle.
  task automatic frame(input logic [DATA_W-1:0] tx,
                       input logic [CS_W-1:0]   cs,
                       input logic cpol, input logic cpha,
                       input logic lsb,
                       input logic [DIV_W-1:0]  dv,
                       input int                mode,
                       input logic [DATA_W-1:0] sdata,
                       input bit                poke);
    int d;
    int exp_lat;
    int edges;
    int sb;
    logic prev;
    logic [DATA_W-1:0] exp_rx;
    d       = int'(dv) + 1;
    exp_lat = (2 * DATA_W + 2) * d + 1;
    edges   = 0;
    sb      = 0;
    prev    = 1'b0;
    r_lat    = 0;
    r_cs_bad = 0;
    r_sclk0  = 1'bx;
    r_rcv    = '0;
    r_arr    = '0;
    bus.start_i     = 1'b1;
    bus.tx_data_i   = tx;
    bus.cs_sel_i    = cs;
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.lsb_first_i = lsb;
    bus.div_i       = dv;
    bus.lpbk_i      = (mode == 3);
    if (mode == 0)
      bus.miso_i = lsb ? sdata[0] : sdata[DATA_W-1];
    else if (mode == 2)
      bus.miso_i = sdata[0];
    else if (mode == 3)
      bus.miso_i = 1'b0;
    for (int k = 1; k <= exp_lat + 8; k++) begin
      @(negedge PCLK);
      bus.start_i = 1'b0;
      if (poke && k == exp_lat / 2) begin
        bus.start_i   = 1'b1;
        bus.tx_data_i = 8'h11;
        bus.cpol_i    = ~cpol;
        bus.cs_sel_i  = ~cs;
      end
      if (bus.done_o) begin
        r_lat = k;
        break;
      end
      if (k == 1) begin
        r_sclk0 = bus.sclk_o;
        prev    = bus.sclk_o;
      end else if (bus.sclk_o != prev) begin
        edges++;
        prev = bus.sclk_o;
        // Odd-numbered edges are leading edges.
        if (edges[0] ^ cpha) begin
          r_arr[sb] = bus.mosi_o;
          if (lsb) r_rcv[sb] = bus.mosi_o;
          else     r_rcv[DATA_W-1-sb] = bus.mosi_o;
          sb++;
        end else if (mode == 0 && sb < DATA_W) begin
          bus.miso_i = lsb ? sdata[sb] : sdata[DATA_W-1-sb];
        end
      end
      if (bus.busy_o && bus.cs_n_o !== ~cs) r_cs_bad++;
      if (mode == 1) bus.miso_i = bus.mosi_o;
    end
    bus.start_i = 1'b0;
    case (mode)
      0:       exp_rx = sdata;
      1:       exp_rx = tx;
      2:       exp_rx = {DATA_W{sdata[0]}};
`ifdef SPI_LOOPBACK_EN
      default: exp_rx = tx;
`else
      default: exp_rx = '0;
`endif
    endcase
    chk("latency", r_lat, exp_lat);
    chk("sclk_edges", edges, 2 * DATA_W);
    chk("sclk_start", r_sclk0, cpol);
    chk("cs_in_frame", r_cs_bad, 0);
    chk("mosi_word", r_rcv, tx);
    chk("rx_data", bus.rx_data_o, exp_rx);
    chk("cs_release", bus.cs_n_o, {CS_W{1'b1}});
    chk("busy_at_done", bus.busy_o, 1'b0);
    chk("sclk_end", bus.sclk_o, cpol);
    @(negedge PCLK);
    chk("done_single", bus.done_o, 1'b0);
    chk("idle_after", bus.busy_o, 1'b0);
  endtask

  task automatic reset_mid();
    int edges;
    bit hit;
    logic prev;
    edges = 0;
    hit   = 0;
    bus.tx_data_i   = 8'h96;
    bus.cs_sel_i    = 4'hF;
    bus.cpol_i      = 1'b0;
    bus.cpha_i      = 1'b0;
    bus.lsb_first_i = 1'b0;
    bus.div_i       = 8'd1;
    bus.lpbk_i      = 1'b0;
    bus.miso_i      = 1'b1;
    bus.start_i     = 1'b1;
    @(negedge PCLK);
    bus.start_i = 1'b0;
    prev = bus.sclk_o;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (bus.sclk_o != prev) begin
        edges++;
        prev = bus.sclk_o;
      end
      if (edges == 7) begin
        hit = 1;
        break;
      end
    end
    chk("rst_reach_bit4", hit, 1'b1);
    chk("rst_busy_before", bus.busy_o, 1'b1);
    PRESETn = 1'b0;
    #1;
    chk("rst_cs_n", bus.cs_n_o, 4'hF);
    chk("rst_sclk", bus.sclk_o, 1'b0);
    chk("rst_mosi", bus.mosi_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_rx", bus.rx_data_o, '0);
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] rtx;
    logic [DATA_W-1:0] rsd;
    bus.start_i     = 1'b0;
    bus.tx_data_i   = '0;
    bus.cs_sel_i    = '0;
    bus.cpol_i      = 1'b0;
    bus.cpha_i      = 1'b0;
    bus.lsb_first_i = 1'b0;
    bus.div_i       = '0;
    bus.lpbk_i      = 1'b0;
    bus.miso_i      = 1'b0;
    PRESETn         = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("reset_cs_n", bus.cs_n_o, 4'hF);
    chk("reset_sclk", bus.sclk_o, 1'b0);
    chk("reset_mosi", bus.mosi_o, 1'b0);
    chk("reset_busy", bus.busy_o, 1'b0);
    chk("reset_done", bus.done_o, 1'b0);
    chk("reset_rx", bus.rx_data_o, '0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    frame(8'hA5, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd1, 1, 8'h00, 0);
    frame(8'h3C, 4'b0010, 1'b1, 1'b1, 1'b1, 8'd1, 2, 8'hFF, 0);
    chk("lsb_wire_order", r_arr, 8'h3C);
    frame(8'hC3, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd2, 0, 8'h6B, 1);
    frame(8'h7E, 4'b0000, 1'b1, 1'b0, 1'b1, 8'd0, 0, 8'h81, 0);
    frame(8'h00, 4'b1111, 1'b0, 1'b0, 1'b0, 8'd0, 0, 8'hFF, 0);

    reset_mid();
    frame(8'h96, 4'b1000, 1'b0, 1'b0, 1'b0, 8'd1, 0, 8'h2D, 0);

    frame(8'h5A, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd1, 3, 8'h00, 0);

    for (int i = 0; i < 24; i++) begin
      rtx = DATA_W'($urandom);
      rsd = DATA_W'($urandom);
      frame(rtx, CS_W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            DIV_W'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)), rsd,
            ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame length in bits (legal 4..32).
REQ-002 SHALL have parameter CS_W, default 4, number of chip-select lines (legal 1..8).
REQ-003 SHALL have parameter DIV_W, default 8, width of clock-divider input.
REQ-004 SHALL have port PCLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port PRESETn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1  transfer request, sampled in IDLE only.
REQ-007 SHALL have port tx_data_i  input  DATA_W  frame to transmit.
REQ-008 SHALL have port cs_sel_i  input  CS_W  one-hot-or-multi-hot slave select mask.
REQ-009 SHALL have ports cpol_i, cpha_i, lsb_first_i  input  1 each  SPI mode and bit order.
REQ-010 SHALL have port div_i  input  DIV_W  half-period = div_i+1 PCLK cycles.
REQ-011 SHALL have port lpbk_i  input  1  loopback request (effective only per REQ-031).
REQ-012 SHALL have port miso_i  input  1  serial data from slave.
REQ-013 SHALL have ports sclk_o, mosi_o  output  1 each  serial clock and data.
REQ-014 SHALL have port cs_n_o  output  CS_W  active-low chip selects.
REQ-015 SHALL have ports busy_o, done_o  output  1 each  busy level, one-cycle completion pulse.
REQ-016 SHALL have port rx_data_o  output  DATA_W  last received frame.

Function
REQ-017 SHALL use FSM states IDLE, CONFIGURE, TRANSFER, TRANSFER_END, encoded 00, 01, 11, 10.
REQ-018 SHALL, in IDLE with start_i=1, latch tx_data_i, cs_sel_i, cpol_i, cpha_i, lsb_first_i, div_i, lpbk_i and enter CONFIGURE next cycle.
REQ-019 SHALL ignore start_i and all config inputs outside IDLE; latched values govern the whole frame.
REQ-020 SHALL, in CONFIGURE, drive cs_n_o low on every bit set in latched mask, sclk_o=CPOL, mosi_o=first bit, for div+1 cycles, then enter TRANSFER.
REQ-021 SHALL, in TRANSFER, generate exactly 2*DATA_W SCLK edges, each div+1 PCLK cycles apart, first edge being the leading edge.
REQ-022 SHALL, for CPHA=0, sample MISO on leading edges and update MOSI on trailing edges (no update after last edge).
REQ-023 SHALL, for CPHA=1, update MOSI on leading edges and sample MISO on trailing edges.
REQ-024 SHALL shift MSB first when lsb_first=0, LSB first when 1; rx_data_o uses same order.
REQ-025 SHALL, in TRANSFER_END, hold sclk_o=CPOL and CS asserted div+1 cycles, then deassert all cs_n_o, pulse done_o, update rx_data_o in same cycle, return to IDLE.
REQ-026 SHALL keep busy_o=1 in every state except IDLE.
REQ-027 SHALL assert done_o exactly (2*DATA_W+2)*(div+1)+1 cycles after the cycle start_i is sampled.
REQ-028 SHALL run a frame with cs_sel_i=0 normally, no cs_n_o asserted.
REQ-029 SHALL allow start_i in the cycle after done_o (back-to-back frames, CS deasserted at least one cycle).

Reset
REQ-030 SHALL, on PRESETn low at any time (including mid-frame), asynchronously force IDLE, sclk_o=0, mosi_o=0, cs_n_o all 1, busy_o=0, done_o=0, rx_data_o=0, counters and shift registers 0.

Configuration
REQ-031 SHALL, with SPI_LOOPBACK_EN defined, sample internal mosi_o instead of miso_i when latched lpbk_i=1; without the macro lpbk_i is ignored and miso_i always used.

Verification
REQ-032 SHALL cover mode 0, DATA_W=8, div=1, tx=0xA5, cs_sel=0001, miso loops to mosi externally -> cs_n_o=1110 during frame, rx_data_o=0xA5, done_o at cycle 37.
REQ-033 SHALL cover mode 3, lsb_first=1, tx=0x3C, miso held 1 -> sclk idles high, mosi bit order 0,0,1,1,1,1,0,0, rx_data_o=0xFF.
REQ-034 SHALL cover start_i pulsed again mid-frame with tx=0x11 -> ignored, single done_o, first frame data unchanged.
REQ-035 SHALL cover PRESETn low during bit 4 -> same-cycle cs_n_o=1111, sclk_o=0, busy_o=0; next start runs a clean frame.
REQ-036 SHALL cover SPI_LOOPBACK_EN defined, lpbk_i=1, miso_i=0, tx=0x5A -> rx_data_o=0x5A; macro undefined -> rx_data_o=0x00.
